// File: rtl/mem_bus_arbiter.sv
// Two-port external bus arbiter: a fetch port and a data port share one
// request/acknowledge bus. The data port has priority, can lock the bus for
// itself, and every transfer is bounded by a timeout that returns an error.
module mem_bus_arbiter #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        async_rst_n,

  // fetch port
  input  logic        if_req,
  input  logic [29:0] if_addr,
  output logic        if_ack,
  output logic [31:0] if_rdata,

  // data port
  input  logic        mem_req,
  input  logic [29:0] mem_addr,
  input  logic [31:0] mem_wdata,
  input  logic [3:0]  mem_mask,
  input  logic        memory_mode,
  input  logic        bus_lock,
  output logic        mem_ack,
  output logic [31:0] mem_rdata,

  // status
  output logic        bus_err,
  output logic        stall,

  // external bus
  output logic        bus_req,
  output logic        bus_we,
  output logic [29:0] bus_addr,
  output logic [31:0] bus_wdata,
  output logic [3:0]  bus_mask,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    IF_BUSY  = 2'd1,
    MEM_BUSY = 2'd2
  } state_t;

  // Counter value at which an unanswered transfer is given up.
  localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT_CYCLES - 1);

  state_t      state_q, state_d;
  logic        lock_hold_q, lock_hold_d;
  logic        lock_req_q, lock_req_d;   // bus_lock captured at data grant
  logic [7:0]  wait_cnt_q, wait_cnt_d;

  logic        bus_req_d, bus_we_d;
  logic [29:0] bus_addr_d;
  logic [31:0] bus_wdata_d;
  logic [3:0]  bus_mask_d;
  logic        if_ack_d, mem_ack_d, bus_err_d;
  logic [31:0] if_rdata_d, mem_rdata_d;

  // Stall the pipeline while either port waits for its acknowledge.
  assign stall = (if_req & ~if_ack) | (mem_req & ~mem_ack);

  // Next-state and next-output logic for the arbitration FSM.
  always_comb begin
    // NOTE: every signal gets a default before the case statement so no path
    // leaves one unassigned, which would otherwise infer a latch.
    state_d     = state_q;
    lock_hold_d = lock_hold_q;
    lock_req_d  = lock_req_q;
    wait_cnt_d  = wait_cnt_q;
    bus_req_d   = bus_req;
    bus_we_d    = bus_we;
    bus_addr_d  = bus_addr;
    bus_wdata_d = bus_wdata;
    bus_mask_d  = bus_mask;
    if_ack_d    = 1'b0;
    mem_ack_d   = 1'b0;
    bus_err_d   = 1'b0;
    if_rdata_d  = if_rdata;
    mem_rdata_d = mem_rdata;

    unique case (state_q)
      IDLE: begin
        // A port whose ack is showing this cycle still holds its request
        // high; the ack term keeps it from being served twice.
        if (mem_req && !mem_ack) begin
          state_d     = MEM_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = memory_mode;
          bus_addr_d  = mem_addr;
          bus_wdata_d = mem_wdata;
          bus_mask_d  = mem_mask;
          lock_req_d  = bus_lock;
          wait_cnt_d  = 8'd0;
        end else if (if_req && !if_ack && !lock_hold_q) begin
          state_d     = IF_BUSY;
          bus_req_d   = 1'b1;
          bus_we_d    = 1'b0;
          bus_addr_d  = if_addr;
          bus_wdata_d = 32'h0;
          bus_mask_d  = 4'b1111;
          wait_cnt_d  = 8'd0;
        end
      end

      IF_BUSY, MEM_BUSY: begin
        // A late bus_ack on the timeout cycle still wins over the abort.
        if (bus_ack) begin
          state_d   = IDLE;
          bus_req_d = 1'b0;
          if (state_q == MEM_BUSY) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = bus_rdata;
            lock_hold_d = lock_req_q;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = bus_rdata;
          end
        end else if (wait_cnt_q == TIMEOUT_LAST) begin
          state_d     = IDLE;
          bus_req_d   = 1'b0;
          bus_err_d   = 1'b1;
          lock_hold_d = 1'b0;
          if (state_q == MEM_BUSY) begin
            mem_ack_d   = 1'b1;
            mem_rdata_d = 32'h0;
          end else begin
            if_ack_d   = 1'b1;
            if_rdata_d = 32'h0;
          end
        end else begin
          wait_cnt_d = wait_cnt_q + 8'd1;
        end
      end

      default: begin
        state_d   = IDLE;
        bus_req_d = 1'b0;
      end
    endcase
  end

  // State and registered outputs; reset abandons any transfer without an ack.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      state_q     <= IDLE;
      lock_hold_q <= 1'b0;
      lock_req_q  <= 1'b0;
      wait_cnt_q  <= 8'd0;
      bus_req     <= 1'b0;
      bus_we      <= 1'b0;
      bus_addr    <= 30'h0;
      bus_wdata   <= 32'h0;
      bus_mask    <= 4'h0;
      if_ack      <= 1'b0;
      mem_ack     <= 1'b0;
      bus_err     <= 1'b0;
      if_rdata    <= 32'h0;
      mem_rdata   <= 32'h0;
    end else begin
      // NOTE: non-blocking assignments so every register samples the values
      // from before this edge, independent of statement order.
      state_q     <= state_d;
      lock_hold_q <= lock_hold_d;
      lock_req_q  <= lock_req_d;
      wait_cnt_q  <= wait_cnt_d;
      bus_req     <= bus_req_d;
      bus_we      <= bus_we_d;
      bus_addr    <= bus_addr_d;
      bus_wdata   <= bus_wdata_d;
      bus_mask    <= bus_mask_d;
      if_ack      <= if_ack_d;
      mem_ack     <= mem_ack_d;
      bus_err     <= bus_err_d;
      if_rdata    <= if_rdata_d;
      mem_rdata   <= mem_rdata_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Bench for mem_bus_arbiter: a bus slave model with programmable ack delay,
// requester tasks, and a monitor that pops expected bus transfers and acks.
module tb_mem_bus_arbiter;

  localparam int unsigned TO = 4;
  localparam int NEVER = 1000;

  logic        clk = 1'b0;
  logic        async_rst_n = 1'b1;
  logic        if_req = 1'b0;
  logic [29:0] if_addr = '0;
  logic        if_ack;
  logic [31:0] if_rdata;
  logic        mem_req = 1'b0;
  logic [29:0] mem_addr = '0;
  logic [31:0] mem_wdata = '0;
  logic [3:0]  mem_mask = '0;
  logic        memory_mode = 1'b0;
  logic        bus_lock = 1'b0;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        bus_err, stall;
  logic        bus_req, bus_we;
  logic [29:0] bus_addr;
  logic [31:0] bus_wdata;
  logic [3:0]  bus_mask;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_rdata = '0;

  mem_bus_arbiter #(.TIMEOUT_CYCLES(TO)) dut (
    .clk(clk), .async_rst_n(async_rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_mask(mem_mask), .memory_mode(memory_mode), .bus_lock(bus_lock),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .bus_err(bus_err), .stall(stall),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_mask(bus_mask),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [29:0] addr;
    logic        we;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } bus_exp_t;

  typedef struct {
    logic        is_mem;
    logic [31:0] rdata;
    logic        err;
  } ack_exp_t;

  bus_exp_t bus_q[$];
  ack_exp_t ack_q[$];
  bus_exp_t cur;
  int total = 0;
  int bad = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  task automatic push_bus(input logic [29:0] a, input logic we, input logic [31:0] wd,
                          input logic [3:0] m);
    bus_exp_t e;
    e.addr = a; e.we = we; e.wdata = wd; e.mask = m;
    bus_q.push_back(e);
  endtask

  task automatic push_ack(input logic is_mem, input logic [31:0] rd, input logic err);
    ack_exp_t e;
    e.is_mem = is_mem; e.rdata = rd; e.err = err;
    ack_q.push_back(e);
  endtask

  // Bus slave: acks after ack_delay cycles of bus_req, or never.
  int          ack_delay = 0;
  int          busy_cnt = 0;
  logic [31:0] slave_data = '0;

  always @(negedge clk) begin
    if (!async_rst_n || !bus_req) begin
      busy_cnt  = 0;
      bus_ack   = 1'b0;
      bus_rdata = 32'h0;
    end else begin
      bus_ack   = (busy_cnt == ack_delay);
      bus_rdata = bus_ack ? slave_data : 32'h0;
      busy_cnt++;
    end
  end

  // Monitor: bus transfer start, stability, acks, stall.
  logic prev_req = 1'b0;

  always @(negedge clk) begin
    if (!async_rst_n) begin
      prev_req = 1'b0;
    end else begin
      if (bus_req && !prev_req) begin
        check("bus_req_expected", bus_q.size() != 0, 1);
        if (bus_q.size() != 0) begin
          cur = bus_q.pop_front();
          check("bus_addr", bus_addr, cur.addr);
          check("bus_we", bus_we, cur.we);
          check("bus_mask", bus_mask, cur.mask);
          if (cur.we) check("bus_wdata", bus_wdata, cur.wdata);
        end
      end else if (bus_req) begin
        check("bus_addr_stable", bus_addr, cur.addr);
        check("bus_mask_stable", bus_mask, cur.mask);
        check("bus_we_stable", bus_we, cur.we);
      end
      prev_req = bus_req;

      if (if_ack || mem_ack) begin
        ack_exp_t e;
        check("ack_expected", ack_q.size() != 0, 1);
        check("single_ack", if_ack && mem_ack, 0);
        if (ack_q.size() != 0) begin
          e = ack_q.pop_front();
          check("ack_port_is_mem", mem_ack, e.is_mem);
          check("ack_rdata", e.is_mem ? mem_rdata : if_rdata, e.rdata);
          check("ack_bus_err", bus_err, e.err);
        end
      end else begin
        check("bus_err_without_ack", bus_err, 0);
      end
      check("stall", stall, (if_req & ~if_ack) | (mem_req & ~mem_ack));
    end
  end

  task automatic do_if(input logic [29:0] a, output int lat);
    logic got;
    @(posedge clk); #1;
    if_addr = a;
    if_req  = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (if_ack) got = 1'b1;
    end
    check("if_ack_seen", got, 1);
    @(posedge clk); #1;
    if_req = 1'b0;
  endtask

  task automatic do_mem(input logic [29:0] a, input logic [31:0] wd, input logic [3:0] m,
                        input logic we, input logic lock, output int lat);
    logic got;
    @(posedge clk); #1;
    mem_addr    = a;
    mem_wdata   = wd;
    mem_mask    = m;
    memory_mode = we;
    bus_lock    = lock;
    mem_req     = 1'b1;
    lat = 0;
    got = 1'b0;
    for (int i = 0; i < 100 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (mem_ack) got = 1'b1;
    end
    check("mem_ack_seen", got, 1);
    @(posedge clk); #1;
    mem_req  = 1'b0;
    bus_lock = 1'b0;
  endtask

  task automatic check_all_zero(input string pfx);
    check({pfx, "_bus_req"}, bus_req, 0);
    check({pfx, "_bus_we"}, bus_we, 0);
    check({pfx, "_if_ack"}, if_ack, 0);
    check({pfx, "_mem_ack"}, mem_ack, 0);
    check({pfx, "_bus_err"}, bus_err, 0);
    check({pfx, "_bus_addr"}, bus_addr, 0);
    check({pfx, "_bus_wdata"}, bus_wdata, 0);
    check({pfx, "_bus_mask"}, bus_mask, 0);
    check({pfx, "_if_rdata"}, if_rdata, 0);
    check({pfx, "_mem_rdata"}, mem_rdata, 0);
    check({pfx, "_stall"}, stall, 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, lat2;
    logic [29:0] a;
    logic [31:0] wd;
    logic        we;

    // Reset state
    #2 async_rst_n = 1'b0;
    #1 check_all_zero("reset");
    repeat (3) @(posedge clk);
    @(negedge clk) async_rst_n = 1'b1;

    // Fetch, ack 3 cycles after bus_req: lands on the timeout point, no error
    ack_delay = 3; slave_data = 32'hDEADBEEF;
    push_bus(30'h100, 1'b0, 32'h0, 4'b1111);
    push_ack(1'b0, 32'hDEADBEEF, 1'b0);
    do_if(30'h100, lat);
    check("if_latency_ack3", lat, 6);

    // Minimum latency data read
    ack_delay = 0; slave_data = 32'h0BADF00D;
    push_bus(30'h040, 1'b0, 32'h0, 4'hC);
    push_ack(1'b1, 32'h0BADF00D, 1'b0);
    do_mem(30'h040, 32'h0, 4'hC, 1'b0, 1'b0, lat);
    check("mem_min_latency", lat, 3);

    // Simultaneous requests: data write first, then fetch
    ack_delay = 1; slave_data = 32'h11112222;
    push_bus(30'h200, 1'b1, 32'h12345678, 4'b0011);
    push_bus(30'h104, 1'b0, 32'h0, 4'b1111);
    push_ack(1'b1, 32'h11112222, 1'b0);
    push_ack(1'b0, 32'h11112222, 1'b0);
    fork
      do_mem(30'h200, 32'h12345678, 4'b0011, 1'b1, 1'b0, lat);
      do_if(30'h104, lat2);
    join
    check("mem_first_latency", lat, 4);

    // Lock: fetch held off until an unlocked data transfer completes
    ack_delay = 0; slave_data = 32'h33334444;
    push_bus(30'h300, 1'b1, 32'hAAAA5555, 4'hF);
    push_ack(1'b1, 32'h33334444, 1'b0);
    do_mem(30'h300, 32'hAAAA5555, 4'hF, 1'b1, 1'b1, lat);
    push_bus(30'h304, 1'b0, 32'h0, 4'hF);
    push_bus(30'h108, 1'b0, 32'h0, 4'b1111);
    push_ack(1'b1, 32'h33334444, 1'b0);
    push_ack(1'b0, 32'h33334444, 1'b0);
    fork
      do_if(30'h108, lat2);
      begin
        repeat (2) @(posedge clk);
        do_mem(30'h304, 32'h0, 4'hF, 1'b0, 1'b0, lat);
      end
    join

    // Timeout on a locked data transfer clears the lock
    ack_delay = 0; slave_data = 32'h55556666;
    push_bus(30'h400, 1'b0, 32'h0, 4'hF);
    push_ack(1'b1, 32'h55556666, 1'b0);
    do_mem(30'h400, 32'h0, 4'hF, 1'b0, 1'b1, lat);
    ack_delay = NEVER;
    push_bus(30'h404, 1'b0, 32'h0, 4'hF);
    push_ack(1'b1, 32'h0, 1'b1);
    do_mem(30'h404, 32'h0, 4'hF, 1'b0, 1'b1, lat);
    check("timeout_latency", lat, 6);
    check("bus_req_after_timeout", bus_req, 0);
    ack_delay = 0;
    push_bus(30'h10C, 1'b0, 32'h0, 4'b1111);
    push_ack(1'b0, 32'h55556666, 1'b0);
    do_if(30'h10C, lat);
    check("if_after_timeout_latency", lat, 3);

    // Reset in the middle of a data transfer
    ack_delay = NEVER;
    push_bus(30'h500, 1'b1, 32'hCAFEF00D, 4'hF);
    @(posedge clk); #1;
    mem_addr = 30'h500; mem_wdata = 32'hCAFEF00D; mem_mask = 4'hF;
    memory_mode = 1'b1; mem_req = 1'b1;
    repeat (3) @(negedge clk);
    check("busy_before_reset", bus_req, 1);
    #2;
    mem_req = 1'b0;
    async_rst_n = 1'b0;
    #1 check_all_zero("midreset");
    @(negedge clk) async_rst_n = 1'b1;
    repeat (3) @(negedge clk);
    ack_delay = 0; slave_data = 32'h77778888;
    push_bus(30'h500, 1'b1, 32'hCAFEF00D, 4'hF);
    push_ack(1'b1, 32'h77778888, 1'b0);
    do_mem(30'h500, 32'hCAFEF00D, 4'hF, 1'b1, 1'b0, lat);
    check("reissue_latency", lat, 3);

    // Mixed transfers with short random delays
    for (int i = 0; i < 8; i++) begin
      ack_delay  = $urandom_range(0, 2);
      slave_data = $urandom;
      a  = 30'($urandom);
      wd = $urandom;
      we = 1'($urandom_range(0, 1));
      if (i % 2 == 1) begin
        push_bus(a, 1'b0, 32'h0, 4'b1111);
        push_ack(1'b0, slave_data, 1'b0);
        do_if(a, lat);
      end else begin
        push_bus(a, we, wd, 4'h5);
        push_ack(1'b1, slave_data, 1'b0);
        do_mem(a, wd, 4'h5, we, 1'b0, lat);
      end
      check("mixed_latency", lat, 3 + ack_delay);
    end

    repeat (4) @(negedge clk);
    check("bus_q_drained", bus_q.size(), 0);
    check("ack_q_drained", ack_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
